mux_key_sync: RTL and testbench

//  Generic key->value lookup multiplexer used throughout the core datapath
//  (memory width select, write-mask generation, byte/half/word slicing).
//  The caller supplies a packed table of (key, data) pairs; a zero-latency

---
 rtl/mux_key_sync.sv | 54 +++++
 tb/tb_mux_key_sync.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_key_sync.sv
// Key->value lookup over a packed (key, data) table; highest-index match wins.
// Combinational result plus a 1-cycle registered copy with synchronous active-low reset.
module mux_key_sync #(
   parameter int                  NR_KEY   = 2,
   parameter int                  KEY_LEN  = 1,
   parameter int                  DATA_LEN = 1,
   parameter logic [DATA_LEN-1:0] DEFAULT  = '0
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [KEY_LEN-1:0]                      key,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]    lut,
   output logic [DATA_LEN-1:0]                     out,
   output logic                                    hit,
   output logic [DATA_LEN-1:0]                     out_q,
   output logic                                    hit_q
);

   localparam int PAIR = KEY_LEN + DATA_LEN;

   logic [NR_KEY-1:0]   match;
   logic [DATA_LEN-1:0] pair_data [NR_KEY];

   genvar i;
   generate
      for (i = 0; i < NR_KEY; i++) begin : g_pair
         assign match[i]     = (lut[PAIR*i + DATA_LEN +: KEY_LEN] == key);
         assign pair_data[i] = lut[PAIR*i +: DATA_LEN];
      end
   endgenerate

   // Ascending scan: a later (higher-index) match overrides an earlier one.
   always_comb begin
      out = DEFAULT;
      hit = 1'b0;
      for (int j = 0; j < NR_KEY; j++) begin
         if (match[j]) begin
            out = pair_data[j];
            hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q <= '0;
         hit_q <= 1'b0;
      end else begin
         out_q <= out;
         hit_q <= hit;
      end
   end

endmodule

// File: tb/tb_mux_key_sync.sv
// Table-driven bench for mux_key_sync over several parameterisations, with a
// queue scoreboard for the registered path.
module tb_mux_key_sync;

   localparam logic [63:0] A = 64'hDEAD_BEEF_0123_4567;
   localparam logic [63:0] B = 64'hCAFE_F00D_89AB_CDEF;
   localparam logic [63:0] X = 64'h1111_2222_3333_4444;
   localparam logic [63:0] Y = 64'h5555_6666_7777_8888;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // u1: KEY 3, DATA 64, 2 pairs
   logic [2:0]   k1;
   logic [133:0] lut1;
   logic [63:0]  o1, oq1;
   logic         h1, hq1;
   // u2: KEY 3, DATA 8, 4 pairs
   logic [2:0]   k2;
   logic [43:0]  lut2;
   logic [7:0]   o2, oq2;
   logic         h2, hq2;
   // u3: byte slicer, 8 pairs of KEY 3 / DATA 64
   logic [2:0]   k3;
   logic [535:0] lut3;
   logic [63:0]  o3, oq3;
   logic         h3, hq3;
   // u4: DEFAULT = AA
   logic [2:0]   k4;
   logic [21:0]  lut4;
   logic [7:0]   o4, oq4;
   logic         h4, hq4;
   // u5: single pair
   logic [1:0]   k5;
   logic [5:0]   lut5;
   logic [3:0]   o5, oq5;
   logic         h5, hq5;

   mux_key_sync #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(64)) u1 (
      .clk(clk), .rst_n(rst_n), .key(k1), .lut(lut1),
      .out(o1), .hit(h1), .out_q(oq1), .hit_q(hq1));
   mux_key_sync #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(8)) u2 (
      .clk(clk), .rst_n(rst_n), .key(k2), .lut(lut2),
      .out(o2), .hit(h2), .out_q(oq2), .hit_q(hq2));
   mux_key_sync #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(64)) u3 (
      .clk(clk), .rst_n(rst_n), .key(k3), .lut(lut3),
      .out(o3), .hit(h3), .out_q(oq3), .hit_q(hq3));
   mux_key_sync #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(8), .DEFAULT(8'hAA)) u4 (
      .clk(clk), .rst_n(rst_n), .key(k4), .lut(lut4),
      .out(o4), .hit(h4), .out_q(oq4), .hit_q(hq4));
   mux_key_sync #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(4)) u5 (
      .clk(clk), .rst_n(rst_n), .key(k5), .lut(lut5),
      .out(o5), .hit(h5), .out_q(oq5), .hit_q(hq5));

   typedef struct {
      int          dut;
      logic [2:0]  key;
      logic [63:0] exp_out;
      logic        exp_hit;
   } vec_t;

   typedef struct {
      int          dut;
      logic [63:0] out;
      logic        hit;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_key(input int dut, input logic [2:0] k);
      case (dut)
         1: k1 = k;
         2: k2 = k;
         3: k3 = k;
         4: k4 = k;
         default: k5 = k[1:0];
      endcase
   endtask

   function automatic logic [63:0] rd_out(input int dut);
      case (dut)
         1: return o1;
         2: return 64'(o2);
         3: return o3;
         4: return 64'(o4);
         default: return 64'(o5);
      endcase
   endfunction

   function automatic logic rd_hit(input int dut);
      case (dut)
         1: return h1;
         2: return h2;
         3: return h3;
         4: return h4;
         default: return h5;
      endcase
   endfunction

   function automatic logic [63:0] rd_outq(input int dut);
      case (dut)
         1: return oq1;
         2: return 64'(oq2);
         3: return oq3;
         4: return 64'(oq4);
         default: return 64'(oq5);
      endcase
   endfunction

   function automatic logic rd_hitq(input int dut);
      case (dut)
         1: return hq1;
         2: return hq2;
         3: return hq3;
         4: return hq4;
         default: return hq5;
      endcase
   endfunction

   // Reference for u2: search from the MSB-end pair down, first hit wins.
   function automatic void model2(input logic [43:0] t, input logic [2:0] k,
                                  output logic [7:0] o, output logic h);
      o = 8'h00;
      h = 1'b0;
      for (int p = 3; p >= 0; p--) begin
         if (t[11*p + 8 +: 3] == k) begin
            o = t[11*p +: 8];
            h = 1'b1;
            break;
         end
      end
   endfunction

   task automatic apply(input int dut, input logic [2:0] k,
                        input logic [63:0] eo, input logic eh, input int idx);
      sb_t e, g;
      @(negedge clk);
      set_key(dut, k);
      #1;
      check($sformatf("v%0d_out", idx), rd_out(dut), eo);
      check($sformatf("v%0d_hit", idx), 64'(rd_hit(dut)), 64'(eh));
      e.dut = dut; e.out = eo; e.hit = eh;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check($sformatf("v%0d_out_q", idx), rd_outq(g.dut), g.out);
      check($sformatf("v%0d_hit_q", idx), 64'(rd_hitq(g.dut)), 64'(g.hit));
   endtask

   initial begin
      logic [63:0] word;
      logic [7:0]  mo;
      logic        mh;

      word = 64'h8877665544332211;
      lut1 = {3'b000, A, 3'b100, B};
      lut2 = {3'd3, 8'hff, 3'd2, 8'h0f, 3'd1, 8'h03, 3'd0, 8'h01};
      for (int i = 0; i < 8; i++) lut3[67*i +: 67] = {3'(i), 56'h0, word[8*i +: 8]};
      lut4 = {3'd1, 8'h11, 3'd2, 8'h22};
      lut5 = {2'b10, 4'h9};
      k1 = 3'b100; k2 = '0; k3 = '0; k4 = '0; k5 = '0;

      vecs.push_back('{1, 3'b000, A,      1'b1});
      vecs.push_back('{1, 3'b100, B,      1'b1});
      vecs.push_back('{1, 3'b010, 64'h0,  1'b0});
      vecs.push_back('{1, 3'b111, 64'h0,  1'b0});
      vecs.push_back('{2, 3'd0,   64'h01, 1'b1});
      vecs.push_back('{2, 3'd1,   64'h03, 1'b1});
      vecs.push_back('{2, 3'd2,   64'h0f, 1'b1});
      vecs.push_back('{2, 3'd3,   64'hff, 1'b1});
      vecs.push_back('{2, 3'd5,   64'h00, 1'b0});
      vecs.push_back('{3, 3'd5,   64'h66, 1'b1});
      vecs.push_back('{3, 3'd0,   64'h11, 1'b1});
      vecs.push_back('{3, 3'd7,   64'h88, 1'b1});
      vecs.push_back('{4, 3'd1,   64'h11, 1'b1});
      vecs.push_back('{4, 3'd2,   64'h22, 1'b1});
      vecs.push_back('{4, 3'd0,   64'hAA, 1'b0});
      vecs.push_back('{5, 3'd2,   64'h9,  1'b1});
      vecs.push_back('{5, 3'd1,   64'h0,  1'b0});

      // Reset: registered outputs cleared, combinational path live.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_q", oq1, 64'h0);
      check("rst_hit_q", 64'(hq1), 64'h0);
      check("rst_out_comb", o1, B);
      check("rst_hit_comb", 64'(h1), 64'h1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < vecs.size(); v++)
         apply(vecs[v].dut, vecs[v].key, vecs[v].exp_out, vecs[v].exp_hit, v);

      // Duplicate keys: first-listed pair wins.
      @(negedge clk);
      lut1 = {3'b001, X, 3'b001, Y};
      apply(1, 3'b001, X, 1'b1, 100);

      // Reset held mid-stream.
      @(negedge clk);
      lut1 = {3'b000, A, 3'b100, B};
      k1 = 3'b100;
      @(posedge clk);
      #1;
      check("seq_pre_out_q", oq1, B);
      check("seq_pre_hit_q", 64'(hq1), 64'h1);
      @(negedge clk);
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("seq_rst%0d_out_q", c), oq1, 64'h0);
         check($sformatf("seq_rst%0d_hit_q", c), 64'(hq1), 64'h0);
         check($sformatf("seq_rst%0d_out", c), o1, B);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("seq_post_out_q", oq1, B);
      check("seq_post_hit_q", 64'(hq1), 64'h1);

      // Table changing every cycle, random keys (duplicates likely).
      for (int r = 0; r < 24; r++) begin
         @(negedge clk);
         lut2 = {$urandom, $urandom};
         k2 = 3'($urandom_range(0, 7));
         model2(lut2, k2, mo, mh);
         apply(2, k2, 64'(mo), mh, 200 + r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
